// File: rtl/i2s_master_link.sv
// Codec-side I2S master: generates AUD_BCLK/AUD_LRCK from clk, serializes one mono
// sample into both slots on AUD_ADCDAT and recovers the left-slot sample from AUD_DACDAT.
module i2s_master_link #(
    parameter int BCLK_DIV    = 4,
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   AUD_BCLK,
    output logic                   AUD_LRCK,
    output logic                   AUD_ADCDAT,
    input  logic                   AUD_DACDAT,
    input  logic [SAMPLE_BITS-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [SAMPLE_BITS-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   tx_underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_LSB  = CNT_W'(SAMPLE_BITS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [DIV_W-1:0]       div;
    logic [CNT_W-1:0]       bit_cnt;
    logic [SAMPLE_BITS-1:0] tx_shift;
    logic [SAMPLE_BITS-1:0] rx_shift;
    logic                   rx_pend;

    logic [CNT_W-1:0]       bit_nxt;
    logic                   div_wrap;
    logic                   frame_start;

    // Slot bit b carries sample[SAMPLE_BITS-b] for b in 1..SAMPLE_BITS (one-bit I2S delay).
    function automatic logic in_sample(input logic [CNT_W-1:0] b);
        in_sample = (b >= CNT_W'(1)) && (b <= CNT_LSB);
    endfunction

    function automatic logic slot_bit(input logic [SAMPLE_BITS-1:0] s,
                                      input logic [CNT_W-1:0] b);
        logic [SAMPLE_BITS-1:0] t;
        t        = s << (b - CNT_W'(1));
        slot_bit = in_sample(b) ? t[SAMPLE_BITS-1] : 1'b0;
    endfunction

    assign bit_nxt  = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
    assign div_wrap = (div == DIV_LAST);

    // A frame starts on RUN entry or on the fall that takes LRCK from right back to left.
    assign frame_start = en && ((state == IDLE) ||
                                (div_wrap && AUD_BCLK && AUD_LRCK && (bit_cnt == CNT_LAST)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            div         <= '0;
            bit_cnt     <= '0;
            AUD_BCLK    <= 1'b0;
            AUD_LRCK    <= 1'b0;
            AUD_ADCDAT  <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_pend     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    div        <= '0;
                    bit_cnt    <= '0;
                    AUD_BCLK   <= 1'b0;
                    AUD_LRCK   <= 1'b0;
                    AUD_ADCDAT <= 1'b0;
                    rx_pend    <= 1'b0;
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        state      <= IDLE;
                        div        <= '0;
                        bit_cnt    <= '0;
                        AUD_BCLK   <= 1'b0;
                        AUD_LRCK   <= 1'b0;
                        AUD_ADCDAT <= 1'b0;
                        rx_pend    <= 1'b0;
                    end else begin
                        if (rx_pend) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            rx_pend  <= 1'b0;
                        end
                        if (div_wrap) begin
                            div      <= '0;
                            AUD_BCLK <= ~AUD_BCLK;
                            if (!AUD_BCLK) begin
                                // Rise: only the left slot feeds the receiver.
                                if (!AUD_LRCK && in_sample(bit_cnt)) begin
                                    rx_shift <= {rx_shift[SAMPLE_BITS-2:0], AUD_DACDAT};
                                    if (bit_cnt == CNT_LSB) rx_pend <= 1'b1;
                                end
                            end else begin
                                bit_cnt    <= bit_nxt;
                                AUD_ADCDAT <= slot_bit(tx_shift, bit_nxt);
                                if (bit_cnt == CNT_LAST) AUD_LRCK <= ~AUD_LRCK;
                            end
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Bit 0 of a new frame is always 0, so the freshly latched sample is
            // not needed on ADCDAT until the following fall.
            if (frame_start) begin
                tx_shift <= tx_valid ? tx_data : '0;
                tx_ready <= tx_valid;
                if (!tx_valid) tx_underrun <= 1'b1;
            end
        end
    end

endmodule
